// File: rtl/regfile_2w_sb.sv
// Two-write-port integer register bank with bypass, busy scoreboard and a post-reset clearing sweep.
// Optional build macro REGFILE_SEED_EN: the sweep loads RB[i] = i instead of 0.
module regfile_2w_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [XLEN-1:0] read1_o,
  output logic [XLEN-1:0] read2_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic            write_enable_i,
  input  logic [AW-1:0]   ld_rd_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic            ld_valid_i,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic            init_done_o
);

  localparam int NREG = 2 ** AW;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rb_q [NREG];

  logic            run;
  logic            we_a;
  logic            we_b;
  logic            we_b_store;
  logic [XLEN-1:0] init_val;

  assign run        = (state_q == RUN);
  assign we_a       = run && write_enable_i && (rd_i != '0);
  assign we_b       = run && ld_valid_i && (ld_rd_i != '0);
  // Port A owns the entry when both ports target the same register.
  assign we_b_store = we_b && !(we_a && (rd_i == ld_rd_i));

`ifdef REGFILE_SEED_EN
  assign init_val = XLEN'(cnt_q);
`else
  assign init_val = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // A new producer issued in the same cycle as the old one's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (ld_valid_i) begin
        busy_d[ld_rd_i] = 1'b0;
      end
      if (issue_valid_i) begin
        busy_d[issue_rd_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        rb_q[cnt_q] <= init_val;
      end else begin
        if (we_b_store) begin
          rb_q[ld_rd_i] <= ld_data_i;
        end
        if (we_a) begin
          rb_q[rd_i] <= write_data_i;
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = rb_q[addr];
    if (!run || (addr == '0)) begin
      val = '0;
    end else if (BYPASS && we_a && (rd_i == addr)) begin
      val = write_data_i;
    end else if (BYPASS && we_b && (ld_rd_i == addr)) begin
      val = ld_data_i;
    end
    return val;
  endfunction

  function automatic logic busy_port(input logic [AW-1:0] addr);
    logic val;
    val = busy_q[addr];
    if (!run || (addr == '0)) begin
      val = 1'b0;
    end else if (BYPASS && ld_valid_i && (ld_rd_i == addr)) begin
      val = 1'b0;
    end
    return val;
  endfunction

  always_comb begin
    read1_o    = read_port(rs1_i);
    read2_o    = read_port(rs2_i);
    rs1_busy_o = busy_port(rs1_i);
    rs2_busy_o = busy_port(rs2_i);
  end

  assign init_done_o = init_done_q;

endmodule

// File: doc/regfile_2w_sb.md
Name: regfile_2w_sb

Overview:
- Parametrised successor to the single-write integer register bank.
- Adds a second write port for late load writeback, write-to-read bypass on both read ports, and a per-register busy scoreboard for multi-cycle producers.
- Adds a sequential post-reset sweep that clears the array one entry per cycle.
- Sits between decode (rs1/rs2 read, busy check, issue) and writeback (ALU port A, load port B).

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, register address width; depth NREG = 2**AW.
- BYPASS, 1, 1 = same-cycle writes are forwarded to the read outputs; 0 = reads return array contents only.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- read1  out  XLEN  read data, port 1 (combinational).
- read2  out  XLEN  read data, port 2 (combinational).
- rs1_busy  out  1  scoreboard bit for rs1 (combinational).
- rs2_busy  out  1  scoreboard bit for rs2 (combinational).
- rd  in  AW  write address, port A (ALU writeback).
- write_data  in  XLEN  write data, port A.
- write_enable  in  1  write strobe, port A.
- ld_rd  in  AW  write address, port B (load writeback).
- ld_data  in  XLEN  write data, port B.
- ld_valid  in  1  write strobe, port B; also clears busy[ld_rd].
- issue_valid  in  1  sets busy[issue_rd].
- issue_rd  in  AW  destination register of an issued multi-cycle op.
- init_done  out  1  high once the post-reset sweep has completed.

Behaviour:
- FSM states: INIT, RUN.
  - rst=1 at an edge: state<=INIT, sweep counter<=0, all busy bits<=0, init_done<=0.
  - INIT: each cycle writes the init value to RB[cnt], cnt<=cnt+1.
  - INIT -> RUN on the cycle cnt==NREG-1 is written; init_done<=1 on that edge.
  - A full sweep takes exactly NREG cycles after rst deasserts.
- rst asserted mid-sweep or in RUN restarts the sweep from cnt=0.
- During INIT:
  - write_enable, ld_valid and issue_valid are ignored.
  - read1/read2 = 0; rs1_busy/rs2_busy = 0.
- Register x0: writes to address 0 are discarded on both ports. Reads of address 0 return 0, and its busy bit is always 0. issue_rd=0 sets nothing.
- Writes in RUN take effect at the rising edge.
  - Port A and port B writing the same nonzero address in one cycle: port A data is stored; ld_valid still clears the busy bit.
- Reads (combinational), priority order when BYPASS=1:
  1. address 0 -> 0.
  2. port A write hit (write_enable && rd==rsX) -> write_data.
  3. port B write hit -> ld_data.
  4. RB[rsX].
- With BYPASS=0 the read returns RB[rsX]; new data is visible the cycle after the write.
- Scoreboard, per register:
  - Set on issue_valid.
  - Clear on ld_valid.
  - Same register set and cleared in one cycle: set wins (new producer).
  - rsX_busy = busy[rsX], except 0 when ld_valid && ld_rd==rsX this cycle (matches the bypass). Applies only when BYPASS=1.
- Widths: all data paths XLEN wide, no truncation or extension; address compares are AW wide.
- Reset values: init_done=0, busy=0. read/busy outputs are 0 while in INIT.

Optional Feature:
- Macro: REGFILE_SEED_EN.
- Defined: the INIT sweep writes RB[i] = i, zero-extended to XLEN (x0 stays 0). Gives deterministic nonzero contents for bring-up benches.
- Not defined: the sweep writes 0 to every entry.
- Sweep length, FSM and all other behaviour are identical in both builds.

Test Plan:
- Sweep: rst high 2 cycles then low -> init_done=0 for exactly 32 cycles, then 1. read1 at rs1=7 = 0, or 7 with REGFILE_SEED_EN.
- Write/read and bypass: in RUN, write_enable=1 rd=5 write_data=0xDEADBEEF, rs1=5 in the same cycle -> read1=0xDEADBEEF that cycle (BYPASS=1). Next cycle, with no write, read1=0xDEADBEEF.
- x0: write_enable=1 rd=0 write_data=0x1234, issue_valid=1 issue_rd=0 -> read1 at rs1=0 = 0 every cycle; rs1_busy=0.
- Dual-write collision: write_enable=1 rd=9 data=0xA, ld_valid=1 ld_rd=9 data=0xB -> read2 at rs2=9 = 0xA in the same cycle and the next.
- Scoreboard:
  - issue_valid rd=12 -> rs1_busy=1 from the next cycle.
  - ld_valid ld_rd=12 ld_data=0x55 -> rs1_busy=0 and read1=0x55 in the same cycle.
  - Simultaneous issue and ld on reg 12 -> busy[12]=1 afterwards.
- Mid-operation reset: assert rst at sweep cycle 10, and again in RUN after writing reg 3=0x77 -> sweep restarts (32 more cycles); reg 3 reads 0 (or 3 with seed) and all busy bits are 0.
